ysyx_24100005_lsu: RTL and testbench
====================================

Name: ysyx_24100005_lsu

Overview:
- Parametrised multi-cycle load/store unit; replaces the single-cycle combinational DPI memory read in the core top.
- Accepts one load/store per transaction from the execute stage (valid/ready).
- Issues one aligned request to the memory port (req/ready, then rvalid ack), then returns the extended load data or error on a response channel (valid/ready).
- Handles byte-lane shifting, write-mask generation, sign/zero extension, misalignment and illegal-funct3 detection.

Parameters:
- XLEN, 32: data width; 32 or 64 only.
- AW, 32: address width.
- RDW, 5: destination register index width.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous reset, active-low (low = reset).
- req_valid  input  1  request valid.
- req_ready  output  1  unit can accept a request.
- req_wen  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V load/store funct3.
- req_addr  input  AW  byte address (rs1 + imm).
- req_wdata  input  XLEN  store data (rs2), LSB-aligned.
- req_rd  input  RDW  load destination register.
- mem_req_valid  output  1  memory request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_addr  output  AW  req_addr with low log2(XLEN/8) bits cleared.
- mem_wen  output  1  store request.
- mem_wdata  output  XLEN  store data shifted to byte lane.
- mem_wmask  output  XLEN/8  byte-enable mask.
- mem_rvalid  input  1  read data valid / write acknowledge.
- mem_rdata  input  XLEN  aligned read word.
- resp_valid  output  1  response valid.
- resp_ready  input  1  consumer accepts response.
- resp_rdata  output  XLEN  extended load data; 0 for stores and errors.
- resp_rd  output  RDW  captured req_rd.
- resp_err  output  2  00 ok, 01 misaligned, 10 illegal funct3.

Behaviour:
- FSM states: IDLE, MEM_REQ, MEM_WAIT, RESP. Reset state is IDLE.
- Reset (rst low, asynchronous): state goes to IDLE and all registered outputs clear to 0. req_ready is 0 while rst is low; otherwise req_ready = (state == IDLE).
- Accept: on req_valid && req_ready in IDLE, capture wen, funct3, addr, wdata and rd, then check the request:
  - Illegal funct3 → RESP with resp_err = 10. Illegal means: load 011/110/111 when XLEN = 32; load 111 when XLEN = 64; store funct3 > 010 (XLEN = 32) or > 011 (XLEN = 64).
  - Else if misaligned (half: addr[0] != 0; word: addr[1:0] != 0; double: addr[2:0] != 0) → RESP with resp_err = 01. No memory request is issued.
  - Else → MEM_REQ.
  - Illegal takes priority over misaligned.
- MEM_REQ: mem_req_valid = 1. mem_addr, mem_wen, mem_wdata and mem_wmask are registered and held stable until mem_req_ready. On mem_req_ready go to MEM_WAIT.
- MEM_WAIT: on mem_rvalid, register resp_rdata (loads only), set resp_err = 00, go to RESP. mem_rvalid in the same cycle as mem_req_ready is not sampled; the earliest ack is the cycle after.
- RESP: resp_valid = 1. All resp_* outputs are held stable until resp_ready, then go to IDLE. A new request can be accepted the cycle after.
- mem_rvalid is ignored in IDLE, MEM_REQ and RESP.
- Minimum latency, accept to resp_valid, with zero-wait memory:
  - Ok access: 3 cycles.
  - Error: 1 cycle.
- Byte offset: off = addr[log2(XLEN/8)-1:0].
- Store shifting and masks: mem_wdata = req_wdata << (8·off). mem_wmask is the size mask shifted left by off:
  - sb: 1
  - sh: 11
  - sw: 1111
  - sd: all ones
- Load extraction: raw = mem_rdata >> (8·off), then truncate to the access size.
  - lb/lh/lw: sign-extend to XLEN.
  - lbu/lhu/lwu: zero-extend.
  - ld: pass through.
- mem_wmask = 0 and mem_wdata = 0 for loads.
- Reset mid-transaction abandons the transaction; no response is produced.

Test Plan:
- XLEN = 32, lb at addr 0x8000_0003, mem_rdata 0x80FF_1234 → mem_addr 0x8000_0000, wmask 0000, resp_rdata 0xFFFF_FF80, resp_err 00, resp_valid 3 cycles after accept.
- lhu at 0x8000_0002, same rdata → resp_rdata 0x0000_80FF; lh at the same address → 0xFFFF_80FF.
- sb at 0x8000_0001, wdata 0x1234_56AB → mem_wdata 0x0000_AB00, mem_wmask 0010, mem_wen 1, resp_rdata 0; sh at 0x8000_0002, wdata 0xBEEF → mem_wdata 0xBEEF_0000, mask 1100.
- lw at 0x8000_0002 → no mem_req_valid, resp_err 01 one cycle after accept; funct3 011 load → resp_err 10; lh with funct3 011 at an odd address → resp_err 10.
- Backpressure: mem_req_ready low 3 cycles, mem_rvalid 2 cycles later, resp_ready low 2 cycles → mem_* and resp_* stable throughout, req_ready 0 until the cycle after the resp handshake; a stray mem_rvalid in RESP changes nothing.
- Drive rst low in MEM_WAIT → all outputs 0 immediately (asynchronous, no clock edge); release, then apply mem_rvalid → ignored, resp_valid stays 0, req_ready 1.

Source files
------------

// File: rtl/ysyx_24100005_lsu.sv
// Multi-cycle load/store unit: one aligned memory request per access,
// byte-lane shifting, write masks, load extension and error detection.
//
// Ports:
//   clk, rst        clock, async active-low reset
//   req_*           execute-stage request (valid/ready)
//   mem_req_*       memory request (valid/ready), aligned address
//   mem_rvalid/rdata memory ack / read word
//   resp_*          response channel (valid/ready), data, rd, error
module ysyx_24100005_lsu #(
    parameter int XLEN = 32,
    parameter int AW   = 32,
    parameter int RDW  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [2:0]        req_funct3,
    input  logic [AW-1:0]     req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [RDW-1:0]    req_rd,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wmask,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [RDW-1:0]    resp_rd,
    output logic [1:0]        resp_err
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MEM_REQ  = 2'd1;
    localparam logic [1:0] S_MEM_WAIT = 2'd2;
    localparam logic [1:0] S_RESP     = 2'd3;

    localparam logic [XLEN-1:0] M8  = XLEN'(8'hFF);
    localparam logic [XLEN-1:0] M16 = XLEN'(16'hFFFF);
    localparam logic [XLEN-1:0] M32 = XLEN'(32'hFFFF_FFFF);

    logic [1:0]      state_q, state_d;
    logic [2:0]      f3_q, f3_d;
    logic [OFFW-1:0] off_q, off_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic            mem_wen_q, mem_wen_d;
    logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]   mem_wmask_q, mem_wmask_d;
    logic [XLEN-1:0] resp_rdata_q, resp_rdata_d;
    logic [RDW-1:0]  resp_rd_q, resp_rd_d;
    logic [1:0]      resp_err_q, resp_err_d;

    // Request decode
    logic [OFFW-1:0] off_in;
    logic            illegal;
    logic            misal;
    logic [NB-1:0]   bmask;
    logic [XLEN-1:0] dmask;
    logic [XLEN-1:0] wdata_sh;
    logic [NB-1:0]   wmask_sh;

    assign off_in = req_addr[OFFW-1:0];

    always_comb begin
        illegal = 1'b0;
        if (req_wen) begin
            if (XLEN == 64) illegal = req_funct3 > 3'b011;
            else            illegal = req_funct3 > 3'b010;
        end else begin
            unique case (req_funct3)
                3'b011, 3'b110: illegal = (XLEN != 64);
                3'b111:         illegal = 1'b1;
                default:        illegal = 1'b0;
            endcase
        end
    end

    always_comb begin
        misal = 1'b0;
        bmask = '1;
        dmask = '1;
        unique case (req_funct3[1:0])
            2'b00: begin
                bmask = NB'(1);
                dmask = M8;
            end
            2'b01: begin
                misal = req_addr[0];
                bmask = NB'(3);
                dmask = M16;
            end
            2'b10: begin
                misal = |req_addr[1:0];
                bmask = NB'(15);
                dmask = M32;
            end
            default: misal = |req_addr[2:0];
        endcase
    end

    // Store bytes beyond the access size are dropped so data matches mask
    assign wdata_sh = (req_wdata & dmask) << {off_in, 3'b000};
    assign wmask_sh = bmask << off_in;

    // Load extraction
    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] ext;

    assign raw = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        unique case (f3_q)
            3'b000:  ext = raw[7]  ? (raw | ~M8)  : (raw & M8);
            3'b001:  ext = raw[15] ? (raw | ~M16) : (raw & M16);
            3'b010:  ext = raw[31] ? (raw | ~M32) : (raw & M32);
            3'b100:  ext = raw & M8;
            3'b101:  ext = raw & M16;
            3'b110:  ext = raw & M32;
            default: ext = raw;
        endcase
    end

    // Next state
    always_comb begin
        state_d      = state_q;
        f3_d         = f3_q;
        off_d        = off_q;
        mem_addr_d   = mem_addr_q;
        mem_wen_d    = mem_wen_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;
        resp_rdata_d = resp_rdata_q;
        resp_rd_d    = resp_rd_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    f3_d         = req_funct3;
                    off_d        = off_in;
                    mem_addr_d   = {req_addr[AW-1:OFFW], OFFW'(0)};
                    mem_wen_d    = req_wen;
                    mem_wdata_d  = req_wen ? wdata_sh : '0;
                    mem_wmask_d  = req_wen ? wmask_sh : '0;
                    resp_rdata_d = '0;
                    resp_rd_d    = req_rd;
                    if (illegal) begin
                        resp_err_d = 2'b10;
                        state_d    = S_RESP;
                    end else if (misal) begin
                        resp_err_d = 2'b01;
                        state_d    = S_RESP;
                    end else begin
                        resp_err_d = 2'b00;
                        state_d    = S_MEM_REQ;
                    end
                end
            end
            S_MEM_REQ: begin
                if (mem_req_ready) state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (mem_rvalid) begin
                    if (!mem_wen_q) resp_rdata_d = ext;
                    resp_err_d = 2'b00;
                    state_d    = S_RESP;
                end
            end
            default: begin
                if (resp_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            f3_q         <= '0;
            off_q        <= '0;
            mem_addr_q   <= '0;
            mem_wen_q    <= 1'b0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
            resp_rdata_q <= '0;
            resp_rd_q    <= '0;
            resp_err_q   <= '0;
        end else begin
            state_q      <= state_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            mem_addr_q   <= mem_addr_d;
            mem_wen_q    <= mem_wen_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
            resp_rdata_q <= resp_rdata_d;
            resp_rd_q    <= resp_rd_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready     = rst && (state_q == S_IDLE);
    assign mem_req_valid = (state_q == S_MEM_REQ);
    assign resp_valid    = (state_q == S_RESP);
    assign mem_addr      = mem_addr_q;
    assign mem_wen       = mem_wen_q;
    assign mem_wdata     = mem_wdata_q;
    assign mem_wmask     = mem_wmask_q;
    assign resp_rdata    = resp_rdata_q;
    assign resp_rd       = resp_rd_q;
    assign resp_err      = resp_err_q;

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Directed testbench for ysyx_24100005_lsu (XLEN = 32).
// Hand-computed vectors for loads, stores, errors, stalls and reset.
module tb_ysyx_24100005_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_addr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_err;

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_24100005_lsu #(.XLEN(32), .AW(32), .RDW(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_rd       (req_rd),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_addr     (mem_addr),
        .mem_wen      (mem_wen),
        .mem_wdata    (mem_wdata),
        .mem_wmask    (mem_wmask),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_rd      (resp_rd),
        .resp_err     (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk($sformatf("%s.req_ready", tag), req_ready, 0);
        chk($sformatf("%s.mem_req_valid", tag), mem_req_valid, 0);
        chk($sformatf("%s.mem_addr", tag), mem_addr, 0);
        chk($sformatf("%s.mem_wen", tag), mem_wen, 0);
        chk($sformatf("%s.mem_wdata", tag), mem_wdata, 0);
        chk($sformatf("%s.mem_wmask", tag), mem_wmask, 0);
        chk($sformatf("%s.resp_valid", tag), resp_valid, 0);
        chk($sformatf("%s.resp_rdata", tag), resp_rdata, 0);
        chk($sformatf("%s.resp_rd", tag), resp_rd, 0);
        chk($sformatf("%s.resp_err", tag), resp_err, 0);
    endtask

    // Zero-wait memory access; mem_rvalid is held high throughout so
    // the MEM_REQ-cycle ack must be ignored.
    task automatic run_ok(input string tag, input logic w,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] rdat,
                          input logic [31:0] e_addr,
                          input logic [31:0] e_wd, input logic [3:0] e_m,
                          input logic [31:0] e_rdata);
        chk($sformatf("%s.req_ready0", tag), req_ready, 1);
        req_valid     = 1'b1;
        req_wen       = w;
        req_funct3    = f3;
        req_addr      = a;
        req_wdata     = wd;
        req_rd        = rd;
        mem_req_ready = 1'b1;
        mem_rvalid    = 1'b1;
        mem_rdata     = rdat;
        resp_ready    = 1'b0;
        tick;
        req_valid = 1'b0;
        chk($sformatf("%s.mreq_v", tag), mem_req_valid, 1);
        chk($sformatf("%s.mem_addr", tag), mem_addr, e_addr);
        chk($sformatf("%s.mem_wen", tag), mem_wen, w);
        chk($sformatf("%s.mem_wdata", tag), mem_wdata, e_wd);
        chk($sformatf("%s.mem_wmask", tag), mem_wmask, e_m);
        chk($sformatf("%s.req_ready1", tag), req_ready, 0);
        tick;
        chk($sformatf("%s.wait_mreq", tag), mem_req_valid, 0);
        chk($sformatf("%s.wait_resp", tag), resp_valid, 0);
        tick;
        chk($sformatf("%s.resp_valid", tag), resp_valid, 1);
        chk($sformatf("%s.resp_rdata", tag), resp_rdata, e_rdata);
        chk($sformatf("%s.resp_err", tag), resp_err, 0);
        chk($sformatf("%s.resp_rd", tag), resp_rd, rd);
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        chk($sformatf("%s.done_resp", tag), resp_valid, 0);
        chk($sformatf("%s.done_ready", tag), req_ready, 1);
    endtask

    task automatic run_err(input string tag, input logic w,
                           input logic [2:0] f3, input logic [31:0] a,
                           input logic [4:0] rd, input logic [1:0] e_err);
        req_valid     = 1'b1;
        req_wen       = w;
        req_funct3    = f3;
        req_addr      = a;
        req_wdata     = 32'hFFFF_FFFF;
        req_rd        = rd;
        mem_req_ready = 1'b1;
        mem_rvalid    = 1'b1;
        mem_rdata     = 32'hA5A5_A5A5;
        resp_ready    = 1'b0;
        tick;
        req_valid = 1'b0;
        chk($sformatf("%s.resp_valid", tag), resp_valid, 1);
        chk($sformatf("%s.mreq_v", tag), mem_req_valid, 0);
        chk($sformatf("%s.resp_err", tag), resp_err, e_err);
        chk($sformatf("%s.resp_rdata", tag), resp_rdata, 0);
        chk($sformatf("%s.resp_rd", tag), resp_rd, rd);
        resp_ready = 1'b1;
        tick;
        resp_ready = 1'b0;
        chk($sformatf("%s.done_ready", tag), req_ready, 1);
        chk($sformatf("%s.done_mreq", tag), mem_req_valid, 0);
    endtask

    initial begin
        rst           = 1'b0;
        req_valid     = 1'b0;
        req_wen       = 1'b0;
        req_funct3    = 3'b000;
        req_addr      = '0;
        req_wdata     = '0;
        req_rd        = '0;
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        resp_ready    = 1'b0;

        tick;
        tick;
        chk_all_zero("reset");
        rst = 1'b1;
        tick;
        chk("post_reset.req_ready", req_ready, 1);

        // Loads
        run_ok("lb", 0, 3'b000, 32'h8000_0003, 0, 5'd3,
               32'h80FF_1234, 32'h8000_0000, 0, 4'b0000,
               32'hFFFF_FF80);
        run_ok("lhu", 0, 3'b101, 32'h8000_0002, 0, 5'd4,
               32'h80FF_1234, 32'h8000_0000, 0, 4'b0000,
               32'h0000_80FF);
        run_ok("lh", 0, 3'b001, 32'h8000_0002, 0, 5'd5,
               32'h80FF_1234, 32'h8000_0000, 0, 4'b0000,
               32'hFFFF_80FF);
        run_ok("lbu", 0, 3'b100, 32'h8000_0001, 0, 5'd6,
               32'h80FF_1234, 32'h8000_0000, 0, 4'b0000,
               32'h0000_0012);
        run_ok("lw", 0, 3'b010, 32'h8000_0004, 0, 5'd7,
               32'h80FF_1234, 32'h8000_0004, 0, 4'b0000,
               32'h80FF_1234);

        // Stores
        run_ok("sb", 1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 5'd8,
               32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_AB00, 4'b0010,
               32'h0);
        run_ok("sh", 1, 3'b001, 32'h8000_0002, 32'h0000_BEEF, 5'd9,
               32'hFFFF_FFFF, 32'h8000_0000, 32'hBEEF_0000, 4'b1100,
               32'h0);
        run_ok("sw", 1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 5'd10,
               32'hFFFF_FFFF, 32'h8000_0010, 32'hDEAD_BEEF, 4'b1111,
               32'h0);

        // Errors
        run_err("lw_mis", 0, 3'b010, 32'h8000_0002, 5'd11, 2'b01);
        run_err("ld_ill", 0, 3'b011, 32'h8000_0000, 5'd12, 2'b10);
        run_err("ill_odd", 0, 3'b011, 32'h8000_0001, 5'd13, 2'b10);
        run_err("lwu_ill", 0, 3'b110, 32'h8000_0000, 5'd14, 2'b10);
        run_err("sd_ill", 1, 3'b011, 32'h8000_0000, 5'd15, 2'b10);
        run_err("sh_mis", 1, 3'b001, 32'h8000_0003, 5'd16, 2'b01);

        // Backpressure: lw 0x8000_0008
        req_valid     = 1'b1;
        req_wen       = 1'b0;
        req_funct3    = 3'b010;
        req_addr      = 32'h8000_0008;
        req_rd        = 5'd17;
        mem_req_ready = 1'b0;
        mem_rvalid    = 1'b1;
        mem_rdata     = 32'h1122_3344;
        tick;
        req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp.mreq_v", mem_req_valid, 1);
            chk("bp.mem_addr", mem_addr, 32'h8000_0008);
            chk("bp.req_ready", req_ready, 0);
            if (i == 2) begin
                mem_req_ready = 1'b1;
                mem_rvalid    = 1'b0;
            end
            tick;
        end
        mem_req_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("bp.wait_mreq", mem_req_valid, 0);
            chk("bp.wait_resp", resp_valid, 0);
            chk("bp.wait_ready", req_ready, 0);
            tick;
        end
        mem_rvalid = 1'b1;
        tick;
        mem_rdata = 32'hCAFE_0000;
        for (int i = 0; i < 3; i++) begin
            chk("bp.resp_valid", resp_valid, 1);
            chk("bp.resp_rdata", resp_rdata, 32'h1122_3344);
            chk("bp.resp_rd", resp_rd, 5'd17);
            chk("bp.resp_err", resp_err, 0);
            chk("bp.resp_ready0", req_ready, 0);
            if (i == 2) resp_ready = 1'b1;
            tick;
        end
        resp_ready = 1'b0;
        mem_rvalid = 1'b0;
        chk("bp.done_ready", req_ready, 1);
        chk("bp.done_resp", resp_valid, 0);

        // Reset in MEM_WAIT
        req_valid     = 1'b1;
        req_wen       = 1'b0;
        req_funct3    = 3'b010;
        req_addr      = 32'h8000_000C;
        req_rd        = 5'd18;
        mem_req_ready = 1'b1;
        mem_rvalid    = 1'b0;
        tick;
        req_valid = 1'b0;
        tick;
        chk("rstmid.in_wait", mem_req_valid, 0);
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("rstmid");
        tick;
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        tick;
        chk("rstmid.resp_valid", resp_valid, 0);
        chk("rstmid.req_ready", req_ready, 1);
        chk("rstmid.mreq_v", mem_req_valid, 0);
        tick;
        chk("rstmid.resp_valid2", resp_valid, 0);
        mem_rvalid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
